// File: rtl/axi4_lite_master_if.sv
// ---------------------------------------------------------------------------
// axi4_lite_master_if
//   AXI4-Lite bus bundle used between axi4_lite_master and its slave.
//   Signals:
//     AW channel : AXI_AWADDR[31:0], AXI_AWVALID, AXI_AWREADY
//     W  channel : AXI_WDATA[31:0], AXI_WSTRB[3:0], AXI_WVALID, AXI_WREADY
//     B  channel : AXI_BRESP[1:0], AXI_BVALID, AXI_BREADY
//     AR channel : AXI_ARADDR[31:0], AXI_ARVALID, AXI_ARREADY
//     R  channel : AXI_RDATA[31:0], AXI_RRESP[1:0], AXI_RVALID, AXI_RREADY
//   Modports: master (initiator side), slave (target side).
// ---------------------------------------------------------------------------
interface axi4_lite_master_if;
    logic [31:0] AXI_AWADDR;
    logic        AXI_AWVALID;
    logic        AXI_AWREADY;
    logic [31:0] AXI_WDATA;
    logic [3:0]  AXI_WSTRB;
    logic        AXI_WVALID;
    logic        AXI_WREADY;
    logic [1:0]  AXI_BRESP;
    logic        AXI_BVALID;
    logic        AXI_BREADY;
    logic [31:0] AXI_ARADDR;
    logic        AXI_ARVALID;
    logic        AXI_ARREADY;
    logic [31:0] AXI_RDATA;
    logic        AXI_RVALID;
    logic [1:0]  AXI_RRESP;
    logic        AXI_RREADY;

    modport master (
        output AXI_AWADDR, AXI_AWVALID, input AXI_AWREADY,
        output AXI_WDATA, AXI_WSTRB, AXI_WVALID, input AXI_WREADY,
        input  AXI_BRESP, AXI_BVALID, output AXI_BREADY,
        output AXI_ARADDR, AXI_ARVALID, input AXI_ARREADY,
        input  AXI_RDATA, AXI_RVALID, AXI_RRESP, output AXI_RREADY
    );

    modport slave (
        input  AXI_AWADDR, AXI_AWVALID, output AXI_AWREADY,
        input  AXI_WDATA, AXI_WSTRB, AXI_WVALID, output AXI_WREADY,
        output AXI_BRESP, AXI_BVALID, input AXI_BREADY,
        input  AXI_ARADDR, AXI_ARVALID, output AXI_ARREADY,
        output AXI_RDATA, AXI_RVALID, AXI_RRESP, input AXI_RREADY
    );
endinterface

// File: rtl/axi4_lite_master.sv
// ---------------------------------------------------------------------------
// axi4_lite_master
//   Initiator end of the AXI4-Lite register bus. Single-word read and write
//   commands arrive on the AMCI command interface, are issued as AXI4-Lite
//   transactions, and the response code / read data are returned. Read and
//   write paths are fully independent.
//
//   Ports:
//     clk, reset            clock; asynchronous active-high reset
//     AMCI_WADDR/WDATA      write command payload, sampled with AMCI_WRITE
//     AMCI_WRITE            single-cycle write request (ignored when busy)
//     AMCI_WIDLE            write path idle / last write result valid
//     AMCI_WRESP            BRESP of the last completed write
//     AMCI_RADDR            read address, sampled with AMCI_READ
//     AMCI_READ             single-cycle read request (ignored when busy)
//     AMCI_RIDLE            read path idle / last read result valid
//     AMCI_RDATA/RRESP      data and response of the last completed read
//     axi                   AXI4-Lite bus (axi4_lite_master_if.master)
//
//   Optional feature: define AXI4LM_TIMEOUT_EN to abort a transaction that
//   has been outstanding for TIMEOUT_CYCLES cycles (response 2'b11, read
//   data 32'hDEAD_BEEF). Without the macro transactions wait indefinitely.
// ---------------------------------------------------------------------------
module axi4_lite_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               AMCI_WADDR,
    input  logic [31:0]               AMCI_WDATA,
    input  logic                      AMCI_WRITE,
    output logic                      AMCI_WIDLE,
    output logic [1:0]                AMCI_WRESP,
    input  logic [31:0]               AMCI_RADDR,
    input  logic                      AMCI_READ,
    output logic                      AMCI_RIDLE,
    output logic [31:0]               AMCI_RDATA,
    output logic [1:0]                AMCI_RRESP,
    axi4_lite_master_if.master        axi
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("axi4_lite_master: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;

    // ---------------- write path ----------------
    wstate_e     wstate_q, wstate_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  wresp_q, wresp_d;

    logic aw_hs, w_hs;
    assign aw_hs = awvalid_q & axi.AXI_AWREADY;
    assign w_hs  = wvalid_q  & axi.AXI_WREADY;

    // ---------------- read path ----------------
    rstate_e     rstate_q, rstate_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic [31:0] araddr_q, araddr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

`ifdef AXI4LM_TIMEOUT_EN
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] wcnt_q, wcnt_d;
    logic [31:0] rcnt_q, rcnt_d;
    logic        w_progress, r_progress;

    // A handshake in the expiring cycle means the slave is alive; let it win.
    assign w_progress = ((wstate_q == W_SEND) && (aw_hs || w_hs)) ||
                        ((wstate_q == W_RESP) && axi.AXI_BVALID);
    assign r_progress = ((rstate_q == R_ADDR) && axi.AXI_ARREADY) ||
                        ((rstate_q == R_DATA) && axi.AXI_RVALID);
`endif

    always_comb begin
        wstate_d  = wstate_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wresp_d   = wresp_q;
`ifdef AXI4LM_TIMEOUT_EN
        wcnt_d    = wcnt_q;
`endif
        unique case (wstate_q)
            W_IDLE: begin
                if (AMCI_WRITE) begin
                    awaddr_d  = AMCI_WADDR;
                    wdata_d   = AMCI_WDATA;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    bready_d  = 1'b1;
                    wstate_d  = W_SEND;
`ifdef AXI4LM_TIMEOUT_EN
                    wcnt_d    = '0;
`endif
                end
            end
            W_SEND: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                // A channel counts as done if it completed earlier or now.
                if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q))
                    wstate_d = W_RESP;
            end
            W_RESP: begin
                if (axi.AXI_BVALID) begin
                    wresp_d  = axi.AXI_BRESP;
                    bready_d = 1'b0;
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
`ifdef AXI4LM_TIMEOUT_EN
        if (wstate_q != W_IDLE) begin
            wcnt_d = wcnt_q + 32'd1;
            if (wcnt_q >= TO_LAST && !w_progress) begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                wresp_d   = 2'b11;
                wstate_d  = W_IDLE;
            end
        end
`endif
    end

    always_comb begin
        rstate_d  = rstate_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        araddr_d  = araddr_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
`ifdef AXI4LM_TIMEOUT_EN
        rcnt_d    = rcnt_q;
`endif
        unique case (rstate_q)
            R_IDLE: begin
                if (AMCI_READ) begin
                    araddr_d  = AMCI_RADDR;
                    arvalid_d = 1'b1;
                    rstate_d  = R_ADDR;
`ifdef AXI4LM_TIMEOUT_EN
                    rcnt_d    = '0;
`endif
                end
            end
            R_ADDR: begin
                if (axi.AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    rstate_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (axi.AXI_RVALID) begin
                    rdata_d  = axi.AXI_RDATA;
                    rresp_d  = axi.AXI_RRESP;
                    rready_d = 1'b0;
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
`ifdef AXI4LM_TIMEOUT_EN
        if (rstate_q != R_IDLE) begin
            rcnt_d = rcnt_q + 32'd1;
            if (rcnt_q >= TO_LAST && !r_progress) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
                rdata_d   = 32'hDEAD_BEEF;
                rresp_d   = 2'b11;
                rstate_d  = R_IDLE;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstate_q  <= W_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wresp_q   <= '0;
            rstate_q  <= R_IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            araddr_q  <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
`ifdef AXI4LM_TIMEOUT_EN
            wcnt_q    <= '0;
            rcnt_q    <= '0;
`endif
        end else begin
            wstate_q  <= wstate_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wresp_q   <= wresp_d;
            rstate_q  <= rstate_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            araddr_q  <= araddr_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
`ifdef AXI4LM_TIMEOUT_EN
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
`endif
        end
    end

    assign axi.AXI_AWADDR  = awaddr_q;
    assign axi.AXI_AWVALID = awvalid_q;
    assign axi.AXI_WDATA   = wdata_q;
    assign axi.AXI_WSTRB   = 4'hF;
    assign axi.AXI_WVALID  = wvalid_q;
    assign axi.AXI_BREADY  = bready_q;
    assign axi.AXI_ARADDR  = araddr_q;
    assign axi.AXI_ARVALID = arvalid_q;
    assign axi.AXI_RREADY  = rready_q;

    assign AMCI_WIDLE = (wstate_q == W_IDLE);
    assign AMCI_WRESP = wresp_q;
    assign AMCI_RIDLE = (rstate_q == R_IDLE);
    assign AMCI_RDATA = rdata_q;
    assign AMCI_RRESP = rresp_q;

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
- Initiator end of the AXI4-Lite register bus.
- Accepts single-word read and write commands from local control logic over a simple command interface (AMCI), issues them as AXI4-Lite transactions, and returns the response code and read data.
- Read and write paths are independent and may run concurrently.
- Sits between local sequencers/CPU-less control FSMs and any AXI4-Lite slave, including the team's register-slave blocks.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles allowed per transaction before abort (used only when the optional feature is compiled in); minimum 2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- AMCI_WADDR  in  32  write address, sampled when AMCI_WRITE=1
- AMCI_WDATA  in  32  write data, sampled when AMCI_WRITE=1
- AMCI_WRITE  in  1  single-cycle write request
- AMCI_WIDLE  out  1  write path idle / result valid
- AMCI_WRESP  out  2  BRESP of the last completed write
- AMCI_RADDR  in  32  read address, sampled when AMCI_READ=1
- AMCI_READ  in  1  single-cycle read request
- AMCI_RIDLE  out  1  read path idle / result valid
- AMCI_RDATA  out  32  RDATA of the last completed read
- AMCI_RRESP  out  2  RRESP of the last completed read
- AXI_AWADDR out 32; AXI_AWVALID out 1; AXI_AWREADY in 1
- AXI_WDATA out 32; AXI_WSTRB out 4 (constant 4'hF); AXI_WVALID out 1; AXI_WREADY in 1
- AXI_BRESP in 2; AXI_BVALID in 1; AXI_BREADY out 1
- AXI_ARADDR out 32; AXI_ARVALID out 1; AXI_ARREADY in 1
- AXI_RDATA in 32; AXI_RVALID in 1; AXI_RRESP in 2; AXI_RREADY out 1

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. While reset=1, all AXI VALID/READY outputs are 0 immediately, without waiting for a clock edge.
- Reset values:
  - AWVALID, WVALID, BREADY, ARVALID, RREADY = 0
  - AMCI_WIDLE = AMCI_RIDLE = 1
  - AMCI_WRESP = AMCI_RRESP = 2'b00
  - AMCI_RDATA = 0
  - AXI_AWADDR/WDATA/ARADDR = 0
- Reset mid-transaction: the in-flight transaction is abandoned and the FSM returns to IDLE. No response is reported.
- Write FSM states: W_IDLE, W_SEND, W_RESP.
  - W_IDLE: AMCI_WIDLE=1.
    - On AMCI_WRITE=1 in cycle N: latch address/data onto AXI_AWADDR/AXI_WDATA, set AWVALID=WVALID=1 and BREADY=1 in cycle N+1, go to W_SEND.
  - W_SEND:
    - AWVALID drops the cycle after the AW handshake; WVALID drops the cycle after the W handshake. The two handshakes may occur in any order or in the same cycle.
    - Once both have occurred, go to W_RESP. If both occur in the same cycle, skip straight to W_RESP.
    - A B handshake seen in W_SEND is illegal per protocol and is ignored.
  - W_RESP: BREADY=1. On BVALID=1, latch AXI_BRESP into AMCI_WRESP, drop BREADY, return to W_IDLE on the next cycle.
  - AMCI_WIDLE = (state==W_IDLE), decoded from registered state. It is low from cycle N+1 until completion.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: on AMCI_READ=1, latch address onto AXI_ARADDR, set ARVALID=1 in N+1, go to R_ADDR.
  - R_ADDR: on the AR handshake, drop ARVALID, set RREADY=1, go to R_DATA.
  - R_DATA: on RVALID=1, latch AXI_RDATA/AXI_RRESP, drop RREADY, return to R_IDLE.
  - AMCI_RIDLE = (state==R_IDLE).
- Command rules:
  - AMCI_WRITE while AMCI_WIDLE=0 is ignored; likewise AMCI_READ while AMCI_RIDLE=0.
  - A command and a completion may coincide: a request in the first idle cycle after completion is accepted normally.
- Results (AMCI_WRESP, AMCI_RDATA, AMCI_RRESP) hold until the next completion of the same path. They are not cleared on a new request.
- Payload stability: AXI address/data outputs stay stable while the corresponding VALID is high (AXI rule). VALID is never withdrawn before its handshake, except by reset or timeout.
- Best-case latency into a zero-wait slave: AMCI_WRITE at N, AW/W handshakes at N+1, WIDLE high again at N+3 if BVALID at N+2.

Optional Feature:
- Macro: AXI4LM_TIMEOUT_EN.
- Enabled:
  - Each path has its own counter, cleared on command acceptance and incremented every non-idle cycle.
  - When a path's counter reaches TIMEOUT_CYCLES, that path drops all its VALID/READY outputs, reports 2'b11 in AMCI_WRESP or AMCI_RRESP (AMCI_RDATA = 32'hDEAD_BEEF), and returns to idle on the next cycle.
  - A handshake in the same cycle as the timeout wins; the timeout is not taken.
- Disabled: no counters; transactions wait forever; the TIMEOUT_CYCLES parameter is unused.

Test Plan:
- Write to zero-wait slave: WADDR=0x0000_0010, WDATA=0xCAFE_F00D, BRESP=00 -> AWADDR/WDATA/WSTRB=F presented at N+1; WIDLE low N+1..N+2, high N+3; WRESP=00.
- Skewed write channels: AWREADY delayed 5 cycles, WREADY immediate, BRESP=2'b10 -> WVALID drops first, AWVALID stays high and stable until its handshake; WRESP=10.
- Read with wait states: RADDR=0x24, ARREADY after 3 cycles, RVALID after 4 more with RDATA=0x1234_5678, RRESP=00 -> RIDLE returns high; RDATA=0x1234_5678.
- Concurrent traffic and busy rules: read and write issued in the same cycle, then a second AMCI_WRITE while busy -> both complete independently; the second write never appears on AW.
- Reset mid-transfer: assert reset while in W_SEND and R_DATA -> all VALID/READY low before the next clk edge; WIDLE=RIDLE=1 and results zeroed.
- AXI4LM_TIMEOUT_EN with TIMEOUT_CYCLES=16, slave never asserts ARREADY -> ARVALID drops after 16 cycles, RRESP=11, RDATA=0xDEAD_BEEF, RIDLE=1.
